shift_add_mult: RTL and testbench

- Sequential unsigned shift-and-add multiplier. Produces a 2n-bit product over multiple cycles.
- Sits directly upstream of the accumulator path. Each iteration drives one 2n-bit add, carry-in 0, into the team's parametric adder; the registered product feeds downstream consumers.
- Start/Done handshake with the controlling FSM. Single clock domain.

---
 rtl/shift_add_mult_pkg.sv | 7 +
 rtl/shift_add_mult_adder.sv | 14 +
 rtl/shift_add_mult.sv | 68 ++++++
 tb/tb_shift_add_mult.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/shift_add_mult_pkg.sv
// shift_add_mult_pkg: shared FSM state type and count-width helper for the shift-and-add multiplier
package shift_add_mult_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction
endpackage

// File: rtl/shift_add_mult_adder.sv
// shift_add_mult_adder: parametric n-bit adder with carry-in, carry-out and signed overflow flag
module shift_add_mult_adder #(
    parameter int n = 16
) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic         carryin,
    output logic [n-1:0] sum,
    output logic         carryout,
    output logic         overflow
);
    assign {carryout, sum} = a + b + {{n{1'b0}}, carryin};
    assign overflow = (a[n-1] == b[n-1]) && (sum[n-1] != a[n-1]);
endmodule

// File: rtl/shift_add_mult.sv
// shift_add_mult: sequential unsigned shift-and-add multiplier; SHIFT_ADD_MULT_EARLY_EXIT_EN ends RUN once the multiplier is exhausted
module shift_add_mult
    import shift_add_mult_pkg::*;
#(
    parameter int n = 8
) (
    input  logic           Clock,
    input  logic           Reset,
    input  logic           Start,
    input  logic [n-1:0]   A,
    input  logic [n-1:0]   B,
    output logic [2*n-1:0] P,
    output logic           Busy,
    output logic           Done
);
    localparam int CW = cnt_w(n);
    state_t state_q, state_d;
    logic [2*n-1:0] a_q, a_d, p_q, p_d, sum;
    logic [n-1:0] b_q, b_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic unused_co, unused_ov;
    logic load, run, last;
    shift_add_mult_adder #(.n(2 * n)) u_add (
        .a(p_q),
        .b(a_q),
        .carryin(1'b0),
        .sum(sum),
        .carryout(unused_co),
        .overflow(unused_ov)
    );
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
        end
    end
    always_comb begin
`ifdef SHIFT_ADD_MULT_EARLY_EXIT_EN
        last = (cnt_q == CW'(1)) || (b_q[n-1:1] == '0);
`else
        last = (cnt_q == CW'(1));
`endif
        state_d = state_q == IDLE ? (Start ? RUN : IDLE) :
                  state_q == RUN  ? (last ? DONE : RUN) : IDLE;
    end
    always_comb begin
        load  = (state_q == IDLE) && Start;
        run   = (state_q == RUN);
        a_d   = load ? {{n{1'b0}}, A} : run ? a_q << 1 : a_q;
        b_d   = load ? B : run ? b_q >> 1 : b_q;
        p_d   = load ? '0 : (run && b_q[0]) ? sum : p_q;
        cnt_d = load ? CW'(n) : run ? cnt_q - CW'(1) : cnt_q;
    end
    always_comb begin
        Busy = (state_q != IDLE);
        Done = (state_q == DONE);
        P    = p_q;
    end
endmodule

// File: tb/tb_shift_add_mult.sv
// tb_shift_add_mult: directed checks of shift_add_mult against a cycle-level arithmetic model
module tb_shift_add_mult;
    logic clk = 0, Reset = 1, Start = 0;
    logic [7:0] A = 0, B = 0;
    logic [15:0] P;
    logic Busy, Done;
    int nchk = 0, nerr = 0, cyc = 0, ph = 0;
    logic [7:0] m_a = 0, m_b = 0;
    logic [15:0] m_p = 0;
    bit chk_en = 0;

    shift_add_mult #(.n(8)) dut (
        .Clock(clk), .Reset(Reset), .Start(Start), .A(A), .B(B),
        .P(P), .Busy(Busy), .Done(Done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int iters(logic [7:0] b);
`ifdef SHIFT_ADD_MULT_EARLY_EXIT_EN
        for (int i = 7; i >= 0; i--) if (b[i]) return i + 1;
        return 1;
`else
        return 8;
`endif
    endfunction

    task automatic check(string name, int act, int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: ph counts cycles since acceptance; after k iterations P = A * (B mod 2^k)
    always @(posedge clk) begin
        if (Reset) begin
            ph = 0;
            m_p = 0;
        end else if (ph == 0) begin
            if (Start) begin
                ph = 1;
                m_a = A;
                m_b = B;
            end
        end else begin
            ph = (ph == iters(m_b) + 1) ? 0 : ph + 1;
        end
        if (!Reset && ph > 0)
            m_p = 16'(int'(m_a) * (int'(m_b) % (1 << (ph - 1))));
    end

    always @(negedge clk) if (chk_en) begin
        check("P", int'(P), int'(m_p));
        check("Busy", int'(Busy), int'(ph != 0));
        check("Done", int'(Done), int'(ph != 0 && ph == iters(m_b) + 1));
    end

    task automatic start_op(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        Start = 1;
        A = a;
        B = b;
        @(negedge clk);
        Start = 0;
    endtask

    task automatic wait_done(output int lat, output int bc);
        lat = 1;
        bc = int'(Busy);
        while (!Done && lat < 40) begin
            @(negedge clk);
            lat++;
            bc += int'(Busy);
        end
        if (!Done) check("done_timeout", 0, 1);
    endtask

    task automatic run_op(string name, input logic [7:0] a, input logic [7:0] b,
                          input int exp_p, input int exp_lat);
        int lat, bc;
        start_op(a, b);
        wait_done(lat, bc);
        check({name, "_p"}, int'(P), exp_p);
        check({name, "_lat"}, lat, exp_lat);
        check({name, "_busy_cycles"}, bc, exp_lat);
        @(negedge clk);
        check({name, "_done_width"}, int'(Done), 0);
        check({name, "_p_hold"}, int'(P), exp_p);
    endtask

    initial begin
        int dc, pd, lat, bc, t;
        int td[3];
        logic [7:0] na[3], nb[3];
        int np[3];
        na = '{2, 4, 9};
        nb = '{3, 5, 9};
        np = '{6, 20, 81};
        @(negedge clk);
        chk_en = 1;
        check("rst_p", int'(P), 0);
        check("rst_busy", int'(Busy), 0);
        check("rst_done", int'(Done), 0);
        @(negedge clk);
        Reset = 0;
        run_op("13x11", 8'd13, 8'd11, 16'h008F, 9);
        run_op("255x255", 8'd255, 8'd255, 16'hFE01, 9);
        run_op("0x200", 8'd0, 8'd200, 0, 9);
        // Start pulses during RUN and DONE must be ignored
        start_op(8'd6, 8'd7);
        dc = 0;
        pd = 0;
        for (int j = 1; j <= 14; j++) begin
            if (j > 1) @(negedge clk);
            Start = (j == 3 || j == 9);
            if (Done) begin
                dc++;
                pd = int'(P);
            end
        end
        Start = 0;
        check("ignore_done_count", dc, 1);
        check("ignore_p", pd, 42);
        check("ignore_idle", int'(Busy), 0);
        // Reset in the middle of RUN aborts without a Done
        start_op(8'd100, 8'd100);
        repeat (3) @(negedge clk);
        Reset = 1;
        @(negedge clk);
        Reset = 0;
        check("abort_p", int'(P), 0);
        check("abort_busy", int'(Busy), 0);
        check("abort_done", int'(Done), 0);
        run_op("3x5", 8'd3, 8'd5, 15, 9);
        // Start held high: back-to-back operations, operands changed on acceptance
        @(negedge clk);
        Start = 1;
        A = na[0];
        B = nb[0];
        for (int op = 0; op < 3; op++) begin
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!Busy && t < 20);
            if (op < 2) begin
                A = na[op + 1];
                B = nb[op + 1];
            end else Start = 0;
            wait_done(lat, bc);
            td[op] = cyc;
            check($sformatf("b2b%0d_p", op), int'(P), np[op]);
        end
        check("b2b_gap1", td[1] - td[0], 10);
        check("b2b_gap2", td[2] - td[1], 10);
`ifdef SHIFT_ADD_MULT_EARLY_EXIT_EN
        @(negedge clk);
        run_op("early_7x1", 8'd7, 8'd1, 7, 2);
        run_op("early_7x128", 8'd7, 8'd128, 896, 9);
        run_op("early_5x0", 8'd5, 8'd0, 0, 2);
`endif
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
